// File: rtl/serial_nibble_receiver.sv
// serial_nibble_receiver
//   Serial-to-parallel frame receiver. Rebuilds DATA_W-bit words from a
//   framed, LSB-first serial line sampled on an external bit strobe:
//     start(0), D0..D(DATA_W-1), [even parity], stop(1)
//   Good words are presented on data_out with a one-cycle data_valid pulse.
//   Bad stop bits pulse frame_err; bad parity pulses parity_err.
//
//   Optional feature macro: PARITY_CHECK_EN
//     defined   -> one even-parity bit follows the last data bit and is checked
//     undefined -> no parity bit on the line, parity_err is held at 0
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active low
//   serial_in   serial line, idles high
//   sample_en   bit strobe; the line is sampled only when 1
//   data_out    last good received word
//   data_valid  1-cycle pulse, data_out just updated
//   frame_err   1-cycle pulse, stop bit sampled as 0
//   busy        1 while a frame is in progress
//   parity_err  1-cycle pulse, parity mismatch
module serial_nibble_receiver #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              sample_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              busy_q, busy_d;
  logic              par_bad;

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;
  // Even parity: data bits plus the parity bit must XOR to zero.
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef PARITY_CHECK_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sample_en && !serial_in) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (sample_en) begin
          // Bits arrive LSB first; place each at its own index.
          for (int i = 0; i < DATA_W; i++)
            if (cnt_q == CNT_W'(i)) shift_d[i] = serial_in;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (sample_en) begin
`ifdef PARITY_CHECK_EN
          par_d = serial_in;
`endif
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_en) begin
          // Straight back to IDLE so a start bit on the next strobe is taken.
          state_d = S_IDLE;
          ferr_d  = !serial_in;
          perr_d  = par_bad;
          if (serial_in && !par_bad) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered from the next state so busy drops with the result pulse.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
`ifdef PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// tb_serial_nibble_receiver
//   Directed bench for serial_nibble_receiver, DATA_W=4, one strobe every
//   4th clock. Expected values are hand-computed constants.
module tb_serial_nibble_receiver;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              serial_in = 1'b1;
  logic              sample_en = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid, frame_err, busy, parity_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int v0, f0, p0;

  serial_nibble_receiver #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .sample_en(sample_en),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .busy(busy), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_valid) n_valid++;
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit: three idle clocks, then one strobe clock. Returns at posedge+1
  // after the strobe edge, so registered results of that strobe are visible.
  task automatic strobe_bit(input logic b);
    serial_in = b;
    sample_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop, input logic par_flip);
    strobe_bit(1'b0);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < DATA_W; i++) strobe_bit(w[i]);
`ifdef PARITY_CHECK_EN
    strobe_bit((^w) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    strobe_bit(stop);
    serial_in = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset, line high
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", parity_err, 0);
    rst = 1'b1;

    // idle strobes with the line high must not start a frame
    strobe_bit(1'b1);
    strobe_bit(1'b1);
    chk("idle_busy", busy, 0);
    chk("idle_no_pulses", n_valid + n_ferr + n_perr, 0);

    // 2. good frame 4'hA
    send_frame(4'hA, 1'b1, 1'b0);
    chk("A_valid", data_valid, 1);
    chk("A_data", data_out, 4'hA);
    chk("A_ferr", frame_err, 0);
    chk("A_busy", busy, 0);
    next_cycle();
    chk("A_valid_one_cycle", data_valid, 0);

    // 3. stop bit 0
    v0 = n_valid; f0 = n_ferr;
    send_frame(4'hF, 1'b0, 1'b0);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_no_valid", data_valid, 0);
    chk("ferr_data_kept", data_out, 4'hA);
    chk("ferr_busy", busy, 0);
    next_cycle();
    chk("ferr_one_cycle", frame_err, 0);
    chk("ferr_valid_count", n_valid - v0, 0);
    chk("ferr_count", n_ferr - f0, 1);

    // 4. back-to-back 4'h3 then 4'hC
    v0 = n_valid;
    send_frame(4'h3, 1'b1, 1'b0);
    chk("b2b_3_valid", data_valid, 1);
    chk("b2b_3_data", data_out, 4'h3);
    send_frame(4'hC, 1'b1, 1'b0);
    chk("b2b_C_valid", data_valid, 1);
    chk("b2b_C_data", data_out, 4'hC);
    next_cycle();
    chk("b2b_valid_count", n_valid - v0, 2);

    // 5. reset after two data strobes, then clean 4'h5
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    strobe_bit(1'b0);
    strobe_bit(1'b1);
    strobe_bit(1'b1);
    chk("abort_busy_pre", busy, 1);
    serial_in = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_data_cleared", data_out, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    send_frame(4'h5, 1'b1, 1'b0);
    chk("post_abort_valid", data_valid, 1);
    chk("post_abort_data", data_out, 4'h5);

`ifdef PARITY_CHECK_EN
    // 6. parity: 4'h7 needs parity bit 1
    next_cycle();
    v0 = n_valid;
    send_frame(4'h7, 1'b1, 1'b1);
    chk("par_bad_perr", parity_err, 1);
    chk("par_bad_valid", data_valid, 0);
    chk("par_bad_data", data_out, 4'h5);
    chk("par_bad_ferr", frame_err, 0);
    next_cycle();
    chk("par_bad_one_cycle", parity_err, 0);
    send_frame(4'h7, 1'b1, 1'b0);
    chk("par_ok_valid", data_valid, 1);
    chk("par_ok_data", data_out, 4'h7);
    chk("par_ok_perr", parity_err, 0);
    // both faults together
    send_frame(4'h7, 1'b0, 1'b1);
    chk("both_perr", parity_err, 1);
    chk("both_ferr", frame_err, 1);
    chk("both_valid", data_valid, 0);
    chk("both_data", data_out, 4'h7);
`else
    next_cycle();
    chk("no_parity_perr_count", n_perr, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
